// File: rtl/rr_sel_pkg.sv
// rtl/rr_sel_pkg.sv - shared constants, state encoding and helpers for rr_sel_gen4
package rr_sel_pkg;

  localparam int NREQ_C    = 4;
  localparam int SEL_W_C   = 2;
  localparam int BURST_W_C = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [NREQ_C-1:0] onehot(input logic [SEL_W_C-1:0] idx);
    return NREQ_C'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational 4-way round-robin pick starting at ptr, skipping excluded inputs
module rr_pick4
  import rr_sel_pkg::*;
(
  input  logic [NREQ_C-1:0]  i_req,
  input  logic [SEL_W_C-1:0] i_ptr,
  input  logic [NREQ_C-1:0]  i_excl,
  output logic               o_any,
  output logic [SEL_W_C-1:0] o_idx
);

  logic [NREQ_C-1:0]  w_masked;
  logic [SEL_W_C-1:0] w_cand;

  assign w_masked = i_req & ~i_excl;

  // Walk from the farthest offset back to ptr so the nearest set bit wins.
  always_comb begin
    o_any  = 1'b0;
    o_idx  = i_ptr;
    w_cand = i_ptr;
    for (int k = NREQ_C - 1; k >= 0; k--) begin
      w_cand = i_ptr + SEL_W_C'(k);
      if (w_masked[w_cand]) begin
        o_any = 1'b1;
        o_idx = w_cand;
      end
    end
  end

endmodule

// File: rtl/rr_sel_gen4.sv
// rtl/rr_sel_gen4.sv - round-robin select generator with burst limit for a 4:1 mux
// Optional per-requester accept counters on o_grant_cnt when RR_SEL_GEN4_STATS_EN is defined.
module rr_sel_gen4
  import rr_sel_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NREQ_C-1:0]  i_req,
  input  logic               i_ready,
  output logic [SEL_W_C-1:0] o_s,
  output logic [NREQ_C-1:0]  o_grant,
`ifdef RR_SEL_GEN4_STATS_EN
  output logic [8*NREQ_C-1:0] o_grant_cnt,
`endif
  output logic               o_valid
);

  localparam logic [BURST_W_C:0] MAX_BURST_L = (BURST_W_C+1)'(MAX_BURST);

  state_e               r_state, w_state_nxt;
  logic [SEL_W_C-1:0]   r_s, w_s_nxt;
  logic [SEL_W_C-1:0]   r_ptr, w_ptr_nxt;
  logic [NREQ_C-1:0]    r_grant, w_grant_nxt;
  logic                 r_valid, w_valid_nxt;
  logic [BURST_W_C-1:0] r_burst, w_burst_nxt;

  logic                 w_accept;
  logic [BURST_W_C:0]   w_burst_inc;
  logic [SEL_W_C-1:0]   w_pick_ptr, w_pick_idx;
  logic [NREQ_C-1:0]    w_pick_excl;
  logic                 w_pick_any;

  assign w_accept    = r_valid & i_ready;
  assign w_burst_inc = {1'b0, r_burst} + 1'b1;

  // One picker serves both cases: fresh search from ptr in IDLE, or
  // "anyone but the current grantee, starting after it" on accept.
  assign w_pick_ptr  = (r_state == GRANT) ? r_s + 1'b1 : r_ptr;
  assign w_pick_excl = (r_state == GRANT) ? onehot(r_s) : '0;

  rr_pick4 u_pick (
    .i_req  (i_req),
    .i_ptr  (w_pick_ptr),
    .i_excl (w_pick_excl),
    .o_any  (w_pick_any),
    .o_idx  (w_pick_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_grant_nxt = r_grant;
    w_valid_nxt = r_valid;
    w_burst_nxt = r_burst;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_s_nxt     = w_pick_idx;
          w_grant_nxt = onehot(w_pick_idx);
          w_valid_nxt = 1'b1;
          w_burst_nxt = '0;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (w_accept) begin
          if (i_req[r_s] && (w_burst_inc < MAX_BURST_L)) begin
            w_burst_nxt = w_burst_inc[BURST_W_C-1:0];
            w_ptr_nxt   = r_s + 1'b1;
          end else if (w_pick_any) begin
            w_s_nxt     = w_pick_idx;
            w_grant_nxt = onehot(w_pick_idx);
            w_burst_nxt = '0;
            w_ptr_nxt   = w_pick_idx + 1'b1;
          end else if (i_req[r_s]) begin
            // Sole requester: restart the burst instead of starving it.
            w_burst_nxt = '0;
            w_ptr_nxt   = r_s + 1'b1;
          end else begin
            w_valid_nxt = 1'b0;
            w_grant_nxt = '0;
            w_ptr_nxt   = r_s + 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_ptr   <= '0;
      r_grant <= '0;
      r_valid <= 1'b0;
      r_burst <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= w_grant_nxt;
      r_valid <= w_valid_nxt;
      r_burst <= w_burst_nxt;
    end
  end

  assign o_s     = r_s;
  assign o_grant = r_grant;
  assign o_valid = r_valid;

`ifdef RR_SEL_GEN4_STATS_EN
  logic [7:0] r_gcnt [NREQ_C];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NREQ_C; k++) r_gcnt[k] <= '0;
    end else if (w_accept && (r_gcnt[r_s] != 8'hFF)) begin
      r_gcnt[r_s] <= r_gcnt[r_s] + 8'd1;
    end
  end

  for (genvar g = 0; g < NREQ_C; g++) begin : g_cnt
    assign o_grant_cnt[8*g +: 8] = r_gcnt[g];
  end
`endif

endmodule

// File: tb/tb_rr_sel_gen4.sv
// tb/tb_rr_sel_gen4.sv - self-checking bench for rr_sel_gen4 (MAX_BURST 4 and 1 instances)
// Stats checks compile in when RR_SEL_GEN4_STATS_EN is defined.
module tb_rr_sel_gen4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       ready;
  logic [1:0] s0, s1;
  logic [3:0] g0, g1;
  logic       v0, v1;
`ifdef RR_SEL_GEN4_STATS_EN
  logic [31:0] gc0, gc1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rr_sel_gen4 #(.MAX_BURST(4)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_ready(ready),
    .o_s(s0), .o_grant(g0),
`ifdef RR_SEL_GEN4_STATS_EN
    .o_grant_cnt(gc0),
`endif
    .o_valid(v0)
  );

  rr_sel_gen4 #(.MAX_BURST(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_ready(ready),
    .o_s(s1), .o_grant(g1),
`ifdef RR_SEL_GEN4_STATS_EN
    .o_grant_cnt(gc1),
`endif
    .o_valid(v1)
  );

  // Reference model, one slot per instance, kept as plain integers.
  int mb[2] = '{4, 1};
  int m_s[2], m_v[2], m_ptr[2], m_run[2];
  int m_gc[2][4];

  function automatic int pick(input logic [3:0] r, input int start, input int skip);
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (start + k) % 4;
      if (r[j] && j != skip) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_s[i] = 0; m_v[i] = 0; m_ptr[i] = 0; m_run[i] = 0;
      for (int k = 0; k < 4; k++) m_gc[i][k] = 0;
    end
  endtask

  // m_run counts beats already accepted in the current burst.
  task automatic model_step(input logic [3:0] r, input logic rd);
    for (int i = 0; i < 2; i++) begin
      if (m_v[i] == 0) begin
        int w;
        w = pick(r, m_ptr[i], -1);
        if (w >= 0) begin
          m_s[i] = w; m_v[i] = 1; m_run[i] = 0;
        end
      end else if (rd) begin
        int c, w;
        c = m_s[i];
        if (m_gc[i][c] < 255) m_gc[i][c]++;
        w = pick(r, (c + 1) % 4, c);
        if (r[c] && (m_run[i] + 1 < mb[i])) begin
          m_run[i]++;
          m_ptr[i] = (c + 1) % 4;
        end else if (w >= 0) begin
          m_s[i] = w; m_run[i] = 0; m_ptr[i] = (w + 1) % 4;
        end else if (r[c]) begin
          m_run[i] = 0; m_ptr[i] = (c + 1) % 4;
        end else begin
          m_v[i] = 0; m_ptr[i] = (c + 1) % 4;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("s0", 32'(s0), 32'(m_s[0]));
    chk("valid0", 32'(v0), 32'(m_v[0]));
    chk("grant0", 32'(g0), m_v[0] != 0 ? (32'd1 << m_s[0]) : 32'd0);
    chk("s1", 32'(s1), 32'(m_s[1]));
    chk("valid1", 32'(v1), 32'(m_v[1]));
    chk("grant1", 32'(g1), m_v[1] != 0 ? (32'd1 << m_s[1]) : 32'd0);
`ifdef RR_SEL_GEN4_STATS_EN
    for (int k = 0; k < 4; k++) begin
      chk("gcnt0", 32'(gc0[8*k +: 8]), 32'(m_gc[0][k]));
      chk("gcnt1", 32'(gc1[8*k +: 8]), 32'(m_gc[1][k]));
    end
`endif
  endtask

  // Inputs change at the falling edge; outputs are checked at the next falling edge.
  task automatic tick(input logic [3:0] r, input logic rd);
    req = r;
    ready = rd;
    @(posedge clk);
    model_step(r, rd);
    @(negedge clk);
    chk_model();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_s0", 32'(s0), 32'd0);
    chk("rst_grant0", 32'(g0), 32'd0);
    chk("rst_valid0", 32'(v0), 32'd0);
    chk("rst_valid1", 32'(v1), 32'd0);
    req = 4'b0000;
    ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_model();

    tick(4'b0000, 1'b1);

    // Sole requester 2: never rotated away by the burst limit.
    for (int k = 0; k < 10; k++) begin
      tick(4'b0100, 1'b1);
      chk("single_s", 32'(s0), 32'd2);
      chk("single_valid", 32'(v0), 32'd1);
    end

    // All requesting: MAX_BURST=1 rotates every beat, MAX_BURST=4 every 4th.
    do_reset();
    for (int k = 0; k < 12; k++) begin
      tick(4'b1111, 1'b1);
      chk("fair_s1", 32'(s1), 32'(k % 4));
      chk("fair_valid1", 32'(v1), 32'd1);
    end

    do_reset();
    for (int k = 0; k < 12; k++) begin
      tick(4'b0011, 1'b1);
      chk("burst_s0", 32'(s0), 32'((k / 4) % 2));
    end

    // Stall on grantee 3 while its request drops; resolves to 0 after accept.
    do_reset();
    tick(4'b1000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick(4'b0001, 1'b0);
      chk("stall_s", 32'(s0), 32'd3);
      chk("stall_valid", 32'(v0), 32'd1);
    end
    tick(4'b0001, 1'b1);
    chk("stall_after_s", 32'(s0), 32'd0);

    // Drain after three accepts of requester 3, then long run for saturation.
    do_reset();
    tick(4'b1000, 1'b1);
    tick(4'b1000, 1'b1);
    tick(4'b1000, 1'b1);
    tick(4'b0000, 1'b1);
    chk("drain_valid", 32'(v0), 32'd0);
    chk("drain_grant", 32'(g0), 32'd0);
    chk("drain_s_hold", 32'(s0), 32'd3);
`ifdef RR_SEL_GEN4_STATS_EN
    chk("drain_gcnt3", 32'(gc0[31:24]), 32'd3);
`endif
    for (int k = 0; k < 300; k++) tick(4'b1000, 1'b1);
`ifdef RR_SEL_GEN4_STATS_EN
    chk("sat_gcnt3", 32'(gc0[31:24]), 32'd255);
`endif

    // Reset mid-grant, then search restarts at index 0.
    for (int k = 0; k < 3; k++) tick(4'b1111, 1'b1);
    do_reset();
    tick(4'b1111, 1'b1);
    chk("post_rst_s0", 32'(s0), 32'd0);
    chk("post_rst_v0", 32'(v0), 32'd1);

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      tick(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_sel_gen4.md
Name: rr_sel_gen4

Overview:
- Upstream select generator for the 4:1 channel mux `mux_4to1_st`.
- Four sources raise requests. The block arbitrates among them round-robin and drives the mux select `s[1:0]`, a one-hot grant, and a valid flag.
- The consumer of the mux output `y` acknowledges each beat with `ready`.
- A burst limit stops one source from monopolising the mux while others wait.

Parameters:
- NREQ, 4: number of requesters. Fixed at 4 to match the mux width.
- SEL_W, 2: select width, equal to log2(NREQ).
- MAX_BURST, 4: maximum consecutive accepted beats granted to one requester while another requester is pending. Legal range 1..15.

Ports:
- clk, input, 1: single clock. All logic updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- req, input, 4: request lines, one bit per mux input I[0..3].
- ready, input, 1: consumer accepts the current beat in any cycle where valid && ready.
- s, output, 2: registered mux select. Wired directly to the mux `s` port.
- grant, output, 4: registered one-hot grant. grant == (1 << s) whenever valid = 1.
- valid, output, 1: registered. Indicates that s selects a granted source.

Behaviour:
- Reset (async assert, sync release):
  - s = 2'b00, grant = 4'b0000, valid = 0.
  - state = IDLE, ptr = 0 (ptr is the highest-priority index for the next arbitration).
  - burst_cnt = 0.
- All outputs are registered. There is no combinational path from req or ready to any output.
- Round-robin pick: the first set bit of req, searching indices ptr, ptr+1, ... modulo 4 (wrap 3 -> 0).
- State IDLE:
  - valid = 0.
  - If req != 0: pick winner w, load s = w, grant = 1 << w, valid = 1, burst_cnt = 0, go to GRANT.
  - Latency: req rises in cycle t, valid = 1 in cycle t+1.
- State GRANT, stall (valid && !ready):
  - s, grant, valid and burst_cnt hold.
  - Grant holds even if req[s] drops; the pending beat must still complete.
- State GRANT, accept (valid && ready). Let c = s.
  - If req[c] = 1 and burst_cnt+1 < MAX_BURST: keep c and increment burst_cnt.
  - Else if any req[j] = 1 with j != c: pick using ptr = c+1, load the new winner, burst_cnt = 0.
  - Else if req[c] = 1 (sole requester): keep c, burst_cnt = 0. A sole requester is never starved by the burst limit.
  - Else: valid = 0, grant = 0, s holds its last value, go to IDLE.
  - After every accept, ptr updates to (new grantee + 1) mod 4, or to c+1 when returning to IDLE.
- Back-to-back accepts have no bubble: valid stays 1 across a grantee change.
- req changes while stalled do not affect the output. They are evaluated only at accept.
- Reset mid-burst: all state clears immediately. The next grant starts the search at index 0.
- burst_cnt width is 4 bits. It never exceeds MAX_BURST-1.

Optional Feature:
- Macro: RR_SEL_GEN4_STATS_EN.
- Defined:
  - Adds output port grant_cnt, 32 bits. This is four 8-bit counters; index k occupies bits [8k+7:8k].
  - Each counter increments on every accepted beat of requester k and saturates at 255.
  - Counters reset to 0 by rst_n.
- Undefined: the port and the counters are absent. All other behaviour is identical.

Decomposition:
- Package rr_sel_pkg holds:
  - constants NREQ_C = 4 and SEL_W_C = 2;
  - state encoding IDLE = 1'b0, GRANT = 1'b1;
  - the burst_cnt width constant.
- Sub-module rr_pick4 (combinational):
  - inputs req[3:0], ptr[1:0], and an exclude mask;
  - outputs any and idx[1:0];
  - used for both IDLE arbitration and re-arbitration on accept.

Test Plan:
- Reset: assert rst_n = 0 mid-grant with req = 4'b1111 -> s = 0, grant = 0, valid = 0 asynchronously. After release, first grant is index 0, one cycle after release.
- Single requester: req = 4'b0100, ready = 1 for 10 cycles -> valid = 1 from cycle 1, s = 2 on every cycle, grant = 4'b0100. No forced rotation.
- Fairness: req = 4'b1111, ready = 1, MAX_BURST = 1 -> s sequence 0, 1, 2, 3, 0, 1, … with valid continuously 1.
- Burst limit: req = 4'b0011, ready = 1, MAX_BURST = 4 -> s = 0 for 4 beats, then s = 1 for 4 beats, then back to 0.
- Stall: grant s = 3, ready = 0 for 5 cycles while req drops to 4'b0001 -> s = 3 and valid = 1 held. On ready = 1, one beat is accepted, then s = 0 on the next cycle.
- Drain and stats (macro defined): req = 4'b1000 for 3 accepted beats, then 0 -> valid = 0 after the third accept and grant_cnt[31:24] = 3. A further 300 beats -> counter saturates at 255.
